// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access controller: operation encoding,
// FSM states, the read-only machine-info address map and the read-modify-write rule.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_RSV = 2'b00,
        CSR_OP_RW  = 2'b01,
        CSR_OP_RS  = 2'b10,
        CSR_OP_RC  = 2'b11
    } csr_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_t;

    localparam logic [11:0] CSR_ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_ADDR_MHARTID   = 12'hF14;

    // Reserved op never reaches a write, so its result is irrelevant; keep old value.
    function automatic logic [31:0] csr_new_val(input csr_op_t op,
                                                input logic [31:0] old_val,
                                                input logic [31:0] src);
        logic [31:0] res;
        case (op)
            CSR_OP_RW: res = src;
            CSR_OP_RS: res = old_val | src;
            CSR_OP_RC: res = old_val & ~src;
            default:   res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_addr_decode.sv
// Combinational address decode: selects the machine-info block or the CSR bank,
// and flags addresses in the architecturally read-only space.
module csr_addr_decode
    import csr_pkg::*;
(
    input  logic [11:0] i_addr,
    output logic        o_sel_info,
    output logic        o_ro_space
);

    assign o_sel_info = (i_addr == CSR_ADDR_MVENDORID) ||
                        (i_addr == CSR_ADDR_MARCHID)   ||
                        (i_addr == CSR_ADDR_MIMPID)    ||
                        (i_addr == CSR_ADDR_MHARTID);

    assign o_ro_space = (i_addr[11:10] == 2'b11);

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR access controller: latches a core request, reads the selected CSR source,
// optionally performs a one-cycle read-modify-write into the bank, then acks.
module csr_access_ctrl
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic        csr_wr_en,
    input  logic [31:0] csr_src,
    output logic        csr_ack,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        csr_busy,
    output logic [11:0] info_addr,
    input  logic [31:0] info_dout,
    input  logic        info_illegal,
    output logic [11:0] bank_addr,
    input  logic [31:0] bank_rdata,
    input  logic        bank_illegal,
    output logic        bank_we,
    output logic [31:0] bank_wdata
);

    csr_state_t  r_state;
    csr_state_t  w_next;

    logic [11:0] r_addr;
    csr_op_t     r_op;
    logic        r_wr_en;
    logic [31:0] r_src;
    logic [31:0] r_old_val;
    logic        r_illegal;

    logic        w_sel_info;
    logic        w_ro_space;
    logic        w_blk_illegal;
    logic        w_illegal_now;
    logic [31:0] w_blk_dout;
    logic [31:0] w_new_val;
    logic        w_accept;
    logic        w_capture;

    csr_addr_decode u_decode (
        .i_addr     (r_addr),
        .o_sel_info (w_sel_info),
        .o_ro_space (w_ro_space)
    );

    assign info_addr = r_addr;
    assign bank_addr = r_addr;

    assign w_blk_dout    = w_sel_info ? info_dout    : bank_rdata;
    assign w_blk_illegal = w_sel_info ? info_illegal : bank_illegal;
    assign w_illegal_now = w_blk_illegal || (r_op == CSR_OP_RSV) ||
                           (r_wr_en && w_ro_space);
    assign w_new_val     = csr_new_val(r_op, r_old_val, r_src);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        csr_busy  = 1'b1;
        csr_ack   = 1'b0;
        bank_we   = 1'b0;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                csr_busy = 1'b0;
                if (csr_req) begin
                    w_accept = 1'b1;
                    w_next   = ST_READ;
                end
            end
            ST_READ: begin
                w_capture = 1'b1;
                w_next    = (!w_illegal_now && r_wr_en) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                bank_we = 1'b1;
                w_next  = ST_RESP;
            end
            ST_RESP: begin
                csr_ack = 1'b1;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Response and write data are forced to zero outside their strobes and on illegal access.
    assign csr_rdata   = (csr_ack && !r_illegal) ? r_old_val : 32'h0;
    assign csr_illegal = csr_ack && r_illegal;
    assign bank_wdata  = bank_we ? w_new_val : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_op      <= CSR_OP_RSV;
            r_wr_en   <= 1'b0;
            r_src     <= '0;
            r_old_val <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= csr_addr;
                r_op    <= csr_op_t'(csr_op);
                r_wr_en <= csr_wr_en;
                r_src   <= csr_src;
            end
            if (w_capture) begin
                r_old_val <= w_blk_dout;
                r_illegal <= w_illegal_now;
            end
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a behavioural info block and CSR bank.
module tb_csr_access_ctrl;

    logic        clk;
    logic        rst;
    logic        csr_req;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic        csr_wr_en;
    logic [31:0] csr_src;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        csr_busy;
    logic [11:0] info_addr;
    logic [31:0] info_dout;
    logic        info_illegal;
    logic [11:0] bank_addr;
    logic [31:0] bank_rdata;
    logic        bank_illegal;
    logic        bank_we;
    logic [31:0] bank_wdata;

    int n_pass  = 0;
    int n_total = 0;

    csr_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .csr_req      (csr_req),
        .csr_addr     (csr_addr),
        .csr_op       (csr_op),
        .csr_wr_en    (csr_wr_en),
        .csr_src      (csr_src),
        .csr_ack      (csr_ack),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .csr_busy     (csr_busy),
        .info_addr    (info_addr),
        .info_dout    (info_dout),
        .info_illegal (info_illegal),
        .bank_addr    (bank_addr),
        .bank_rdata   (bank_rdata),
        .bank_illegal (bank_illegal),
        .bank_we      (bank_we),
        .bank_wdata   (bank_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Machine-info block: only mvendorid is non-zero.
    always_comb begin
        info_illegal = 1'b0;
        case (info_addr)
            12'hF11: info_dout = 32'hDEADBEEF;
            default: info_dout = 32'h0;
        endcase
    end

    // CSR bank: 0x7FF is unimplemented, 0xC00 is a fixed read-only pattern.
    logic [31:0] bank_mem [0:4095];
    int          wr_count = 0;
    assign bank_illegal = (bank_addr == 12'h7FF);
    assign bank_rdata   = (bank_addr == 12'hC00) ? 32'hC0DE0C00 : bank_mem[bank_addr];
    always @(posedge clk) begin
        if (bank_we) begin
            bank_mem[bank_addr] <= bank_wdata;
            wr_count <= wr_count + 1;
        end
    end

    // Issues one request starting at a falling edge and observes it until ack (bounded).
    task automatic run_access(input logic [11:0] a, input logic [1:0] op, input logic we,
                              input logic [31:0] src, output int lat, output logic [31:0] rd,
                              output logic ill, output int nwr, output logic [31:0] wd);
        int w0;
        w0  = wr_count;
        lat = 0;
        rd  = '0;
        ill = 1'b0;
        wd  = '0;
        csr_req = 1'b1; csr_addr = a; csr_op = op; csr_wr_en = we; csr_src = src;
        @(posedge clk);
        #1 csr_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bank_we) wd = bank_wdata;
            if (csr_ack) begin
                lat = k + 1;
                rd  = csr_rdata;
                ill = csr_illegal;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        nwr = wr_count - w0;
    endtask

    task automatic test_reset();
        rst = 1'b1; csr_req = 1'b0; csr_addr = 12'hABC; csr_op = 2'b01;
        csr_wr_en = 1'b1; csr_src = 32'hFFFFFFFF;
        @(posedge clk); #1;
        n_total++; if (csr_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", csr_ack); else n_pass++;
        n_total++; if (csr_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", csr_rdata); else n_pass++;
        n_total++; if (csr_illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", csr_illegal); else n_pass++;
        n_total++; if (csr_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", csr_busy); else n_pass++;
        n_total++; if ({bank_we, bank_wdata} !== 33'h0) $display("FAIL reset_bank_wr got %b/%h want 0/0", bank_we, bank_wdata); else n_pass++;
        n_total++; if ({info_addr, bank_addr} !== 24'h0) $display("FAIL reset_addr got %h/%h want 0/0", info_addr, bank_addr); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_info_read();
        int lat, nwr; logic [31:0] rd, wd; logic ill;
        run_access(12'hF14, 2'b10, 1'b0, 32'h0, lat, rd, ill, nwr, wd);
        n_total++; if (lat !== 2) $display("FAIL mhartid_lat got %0d want 2", lat); else n_pass++;
        n_total++; if (rd !== 32'h0 || ill !== 1'b0) $display("FAIL mhartid_resp got %h/%b want 0/0", rd, ill); else n_pass++;
        n_total++; if (nwr !== 0) $display("FAIL mhartid_nowrite got %0d want 0", nwr); else n_pass++;
        run_access(12'hF11, 2'b10, 1'b0, 32'h0, lat, rd, ill, nwr, wd);
        n_total++; if (lat !== 2) $display("FAIL mvendorid_lat got %0d want 2", lat); else n_pass++;
        n_total++; if (rd !== 32'hDEADBEEF || ill !== 1'b0) $display("FAIL mvendorid_resp got %h/%b want deadbeef/0", rd, ill); else n_pass++;
    endtask

    task automatic test_ro_write();
        int lat, nwr; logic [31:0] rd, wd; logic ill;
        run_access(12'hF12, 2'b01, 1'b1, 32'h1, lat, rd, ill, nwr, wd);
        n_total++; if (lat !== 2) $display("FAIL ro_info_lat got %0d want 2", lat); else n_pass++;
        n_total++; if (ill !== 1'b1 || rd !== 32'h0) $display("FAIL ro_info_resp got %b/%h want 1/0", ill, rd); else n_pass++;
        n_total++; if (nwr !== 0) $display("FAIL ro_info_nowrite got %0d want 0", nwr); else n_pass++;
        run_access(12'hC00, 2'b10, 1'b1, 32'h3, lat, rd, ill, nwr, wd);
        n_total++; if (ill !== 1'b1 || nwr !== 0 || rd !== 32'h0) $display("FAIL ro_bank_write got ill=%b wr=%0d rd=%h want 1/0/0", ill, nwr, rd); else n_pass++;
        run_access(12'hC00, 2'b10, 1'b0, 32'h0, lat, rd, ill, nwr, wd);
        n_total++; if (lat !== 2 || ill !== 1'b0 || rd !== 32'hC0DE0C00) $display("FAIL ro_bank_read got lat=%0d ill=%b rd=%h want 2/0/c0de0c00", lat, ill, rd); else n_pass++;
    endtask

    task automatic test_rs_rc();
        int lat, nwr; logic [31:0] rd, wd; logic ill;
        run_access(12'h300, 2'b01, 1'b1, 32'h0000000F, lat, rd, ill, nwr, wd);
        n_total++; if (lat !== 3 || nwr !== 1 || wd !== 32'h0F) $display("FAIL rw_seed got lat=%0d wr=%0d wd=%h want 3/1/f", lat, nwr, wd); else n_pass++;
        run_access(12'h300, 2'b10, 1'b1, 32'h00000030, lat, rd, ill, nwr, wd);
        n_total++; if (wd !== 32'h3F || nwr !== 1) $display("FAIL rs_wdata got %h wr=%0d want 3f/1", wd, nwr); else n_pass++;
        n_total++; if (lat !== 3) $display("FAIL rs_lat got %0d want 3", lat); else n_pass++;
        n_total++; if (rd !== 32'h0F || ill !== 1'b0) $display("FAIL rs_rdata got %h/%b want f/0", rd, ill); else n_pass++;
        run_access(12'h300, 2'b11, 1'b1, 32'h0000000F, lat, rd, ill, nwr, wd);
        n_total++; if (wd !== 32'h30 || rd !== 32'h3F || lat !== 3) $display("FAIL rc_access got wd=%h rd=%h lat=%0d want 30/3f/3", wd, rd, lat); else n_pass++;
        run_access(12'h300, 2'b10, 1'b0, 32'h0, lat, rd, ill, nwr, wd);
        n_total++; if (rd !== 32'h30 || lat !== 2 || nwr !== 0) $display("FAIL rs_readonly got rd=%h lat=%0d wr=%0d want 30/2/0", rd, lat, nwr); else n_pass++;
    endtask

    task automatic test_illegal();
        int lat, nwr; logic [31:0] rd, wd; logic ill;
        run_access(12'h300, 2'b00, 1'b1, 32'hFFFFFFFF, lat, rd, ill, nwr, wd);
        n_total++; if (ill !== 1'b1 || rd !== 32'h0 || lat !== 2) $display("FAIL rsv_op got ill=%b rd=%h lat=%0d want 1/0/2", ill, rd, lat); else n_pass++;
        n_total++; if (nwr !== 0) $display("FAIL rsv_op_nowrite got %0d want 0", nwr); else n_pass++;
        run_access(12'h7FF, 2'b01, 1'b1, 32'h5, lat, rd, ill, nwr, wd);
        n_total++; if (ill !== 1'b1 || nwr !== 0 || lat !== 2) $display("FAIL unmapped got ill=%b wr=%0d lat=%0d want 1/0/2", ill, nwr, lat); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int w0, acks; int lat, nwr; logic [31:0] rd, wd; logic ill;
        w0 = wr_count;
        acks = 0;
        csr_req = 1'b1; csr_addr = 12'h300; csr_op = 2'b01; csr_wr_en = 1'b1; csr_src = 32'h55;
        @(posedge clk);
        #1 csr_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (bank_we !== 1'b1) $display("FAIL mid_in_write got %b want 1", bank_we); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++; if ({bank_we, bank_wdata} !== 33'h0 || csr_busy !== 1'b0) $display("FAIL mid_rst_drop got we=%b wd=%h busy=%b want 0/0/0", bank_we, bank_wdata, csr_busy); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (csr_ack) acks++;
        end
        n_total++; if (acks !== 0 || csr_busy !== 1'b0) $display("FAIL mid_no_ack got acks=%0d busy=%b want 0/0", acks, csr_busy); else n_pass++;
        n_total++; if (wr_count - w0 !== 0) $display("FAIL mid_no_write got %0d want 0", wr_count - w0); else n_pass++;
        run_access(12'h300, 2'b10, 1'b0, 32'h0, lat, rd, ill, nwr, wd);
        n_total++; if (rd !== 32'h30) $display("FAIL mid_bank_kept got %h want 30", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acks, good, w0;
        acks = 0; good = 0;
        csr_req = 1'b1; csr_addr = 12'h300; csr_op = 2'b10; csr_wr_en = 1'b0; csr_src = 32'h0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (csr_ack) begin
                acks++;
                if (csr_rdata === 32'h30) good++;
            end
        end
        n_total++; if (acks !== 3 || good !== 3) $display("FAIL b2b_read got acks=%0d good=%0d want 3/3", acks, good); else n_pass++;
        n_total++; if (csr_busy !== 1'b0) $display("FAIL b2b_idle got busy=%b want 0", csr_busy); else n_pass++;
        acks = 0;
        w0 = wr_count;
        csr_wr_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (csr_ack) acks++;
        end
        csr_req = 1'b0;
        n_total++; if (acks !== 2 || wr_count - w0 !== 2) $display("FAIL b2b_write got acks=%0d wr=%0d want 2/2", acks, wr_count - w0); else n_pass++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_info_read();
        test_ro_write();
        test_rs_rc();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port csr_req, input, 1, core requests a CSR access; sampled only in IDLE.
REQ-004 SHALL have port csr_addr, input, 12, CSR address.
REQ-005 SHALL have port csr_op, input, 2, operation: 01 RW, 10 RS, 11 RC, 00 reserved.
REQ-006 SHALL have port csr_wr_en, input, 1, write intent; core drives 0 for RS/RC with rs1=x0.
REQ-007 SHALL have port csr_src, input, 32, source operand (rs1 value or zero-extended uimm).
REQ-008 SHALL have port csr_ack, output, 1, one-cycle completion strobe.
REQ-009 SHALL have port csr_rdata, output, 32, old CSR value; valid while csr_ack=1.
REQ-010 SHALL have port csr_illegal, output, 1, illegal-instruction flag; valid while csr_ack=1.
REQ-011 SHALL have port csr_busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port info_addr, output, 12, address to the read-only machine-info block.
REQ-013 SHALL have ports info_dout (input, 32) and info_illegal (input, 1), combinational response from the info block.
REQ-014 SHALL have port bank_addr, output, 12, address to the writable CSR bank.
REQ-015 SHALL have ports bank_rdata (input, 32) and bank_illegal (input, 1), combinational response from the bank.
REQ-016 SHALL have ports bank_we (output, 1) and bank_wdata (output, 32), one-cycle write to the bank.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-018 IDLE: when csr_req=1, latch addr/op/wr_en/src and go to READ; otherwise stay.
REQ-019 SHALL drive info_addr and bank_addr from the latched address.
REQ-020 Routing: addresses 0xF11-0xF14 select the info block; all other addresses select the bank.
REQ-021 READ: capture the selected block's dout into old_val and its illegal flag into the illegal register.
REQ-022 Illegal conditions (OR): selected block flags illegal; op=00; wr_en=1 and addr[11:10]=2'b11 (read-only space).
REQ-023 READ -> WRITE when legal and wr_en=1; READ -> RESP otherwise.
REQ-024 new_val SHALL be: RW src; RS old_val|src; RC old_val&~src; 32-bit, no width extension.
REQ-025 WRITE: assert bank_we=1 with bank_wdata=new_val for exactly one cycle, then go to RESP.
REQ-026 RESP: assert csr_ack=1 for one cycle with csr_rdata=old_val, then go to IDLE.
REQ-027 On illegal access, csr_rdata SHALL be 0 and bank_we SHALL never assert.
REQ-028 Latency, request accepted at edge N: ack at cycle N+2 when no write, N+3 when writing.
REQ-029 csr_req outside IDLE SHALL be ignored; a new request is accepted in the cycle after csr_ack (back-to-back throughput: one access per 3-4 cycles).
REQ-030 bank_we=0 and csr_ack=0 in every state other than WRITE and RESP respectively.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, csr_ack=0, csr_rdata=0, csr_illegal=0, csr_busy=0, bank_we=0, bank_wdata=0, and all latched registers to 0.
REQ-032 rst asserted mid-operation SHALL abort the access with no write and no ack; the operation is not replayed.

Structure
REQ-033 Shared package csr_pkg SHALL hold the csr_op_t enum, the FSM state enum, and the info-block address constants 0xF11-0xF14.
REQ-034 Address routing and read-only checks SHALL be one sub-module, csr_addr_decode (combinational); there are no other sub-modules.

Verification
REQ-035 Read mhartid: req addr=0xF14, op=RS, wr_en=0 -> ack at N+2, rdata=0x00000000, illegal=0, no bank_we.
REQ-036 Read mvendorid: req addr=0xF11, op=RS, wr_en=0 -> ack at N+2, rdata=0xDEADBEEF, illegal=0.
REQ-037 Write to read-only space: addr=0xF12, op=RW, wr_en=1, src=0x1 -> ack at N+2, illegal=1, rdata=0, no bank_we.
REQ-038 RS and RC on the bank: addr=0x300, bank holds 0x0000000F. RS with src=0x30 -> bank_we with wdata=0x3F, ack at N+3 with rdata=0x0F. Then RC with src=0x0F -> wdata=0x30.
REQ-039 Reserved op and an unmapped address: op=00 -> illegal=1. Then addr=0x7FF with bank_illegal=1 -> illegal=1, no write.
REQ-040 Reset and ignored requests: rst pulsed during WRITE -> bank_we drops immediately, no ack, FSM back in IDLE. A csr_req held during busy -> exactly one access per ack.
